// File: rtl/mem_load_align_if.sv
// Bus bundle for the load aligner: pipeline request/response handshake plus
// the single-word RAM read port. The aligner is the slave; the pipeline/RAM
// side (or a testbench) is the master.
interface mem_load_align_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  ld_req_valid;
   logic                  ld_req_ready;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [2:0]            ld_func3;
   logic                  ram_req;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_gnt;
   logic                  ram_rvalid;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ld_rsp_valid;
   logic                  ld_rsp_ready;
   logic [DATA_WIDTH-1:0] ld_rsp_data;
   logic                  load_access_missalign;

   modport slave (
      input  ld_req_valid, ld_addr, ld_func3,
      input  ram_gnt, ram_rvalid, ram_rdata,
      input  ld_rsp_ready,
      output ld_req_ready, ram_req, ram_addr,
      output ld_rsp_valid, ld_rsp_data, load_access_missalign
   );

   modport master (
      output ld_req_valid, ld_addr, ld_func3,
      output ram_gnt, ram_rvalid, ram_rdata,
      output ld_rsp_ready,
      input  ld_req_ready, ram_req, ram_addr,
      input  ld_rsp_valid, ld_rsp_data, load_access_missalign
   );
endinterface

// File: rtl/mem_load_align.sv
// Load aligner: accepts one load at a time, fetches the containing word from
// RAM, then selects and sign/zero-extends the requested byte/half/word.
// Misaligned or unsupported loads are answered directly without touching RAM.
module mem_load_align #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   mem_load_align_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   state_t                r_state;
   logic [1:0]            r_idx;
   logic [2:0]            r_func3;
   logic                  r_ldReqReady;
   logic                  r_ramReq;
   logic [ADDR_WIDTH-1:0] r_ramAddr;
   logic                  r_rspValid;
   logic [DATA_WIDTH-1:0] r_rspData;
   logic                  r_missAlign;

   logic                  w_misaligned;
   logic                  w_illegal;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_fmtData;

   // Classify the incoming request: unsupported func3 vs misaligned access
   always_comb begin
      w_misaligned = 1'b0;
      w_illegal    = 1'b0;
      case (bus.ld_func3)
         F3_LB, F3_LBU: w_misaligned = 1'b0;
         F3_LH, F3_LHU: w_misaligned = bus.ld_addr[0];
         F3_LW:         w_misaligned = (bus.ld_addr[1:0] != 2'b00);
         default:       w_illegal    = 1'b1;
      endcase
   end

   // Extract and extend the addressed byte/half from the returned RAM word
   always_comb begin
      w_byte    = bus.ram_rdata[8*r_idx +: 8];
      w_half    = r_idx[1] ? bus.ram_rdata[16 +: 16] : bus.ram_rdata[0 +: 16];
      w_fmtData = '0;
      case (r_func3)
         F3_LB:   w_fmtData = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         F3_LBU:  w_fmtData = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         F3_LH:   w_fmtData = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         F3_LHU:  w_fmtData = {{(DATA_WIDTH-16){1'b0}}, w_half};
         F3_LW:   w_fmtData = bus.ram_rdata;
         default: w_fmtData = '0;
      endcase
   end

   // Control FSM with all outputs registered; reset drops any pending load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_func3      <= '0;
         r_ldReqReady <= 1'b1;
         r_ramReq     <= 1'b0;
         r_ramAddr    <= '0;
         r_rspValid   <= 1'b0;
         r_rspData    <= '0;
         r_missAlign  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.ld_req_valid) begin
                  r_idx        <= bus.ld_addr[1:0];
                  r_func3      <= bus.ld_func3;
                  r_ldReqReady <= 1'b0;
                  if (w_misaligned) begin
                     r_state     <= RSP;
                     r_rspValid  <= 1'b1;
                     r_rspData   <= '0;
                     r_missAlign <= 1'b1;
                  end else if (w_illegal) begin
                     r_state     <= RSP;
                     r_rspValid  <= 1'b1;
                     r_rspData   <= '0;
                     r_missAlign <= 1'b0;
                  end else begin
                     r_state   <= REQ;
                     r_ramReq  <= 1'b1;
                     r_ramAddr <= {bus.ld_addr[ADDR_WIDTH-1:2], 2'b00};
                  end
               end
            end
            REQ: begin
               if (bus.ram_gnt) begin
                  r_state  <= WAIT;
                  r_ramReq <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.ram_rvalid) begin
                  r_state     <= RSP;
                  r_rspValid  <= 1'b1;
                  r_rspData   <= w_fmtData;
                  r_missAlign <= 1'b0;
               end
            end
            RSP: begin
               if (bus.ld_rsp_ready) begin
                  r_state      <= IDLE;
                  r_rspValid   <= 1'b0;
                  r_rspData    <= '0;
                  r_missAlign  <= 1'b0;
                  r_ldReqReady <= 1'b1;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_ldReqReady <= 1'b1;
               r_ramReq     <= 1'b0;
               r_rspValid   <= 1'b0;
               r_rspData    <= '0;
               r_missAlign  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ld_req_ready          = r_ldReqReady;
   assign bus.ram_req               = r_ramReq;
   assign bus.ram_addr              = r_ramAddr;
   assign bus.ld_rsp_valid          = r_rspValid;
   assign bus.ld_rsp_data           = r_rspData;
   assign bus.load_access_missalign = r_missAlign;

endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align: table of single loads with immediate
// RAM handshakes, then hand-written stall and reset-in-flight sequences.
module tb_mem_load_align;

   logic clk;
   logic rst_n;
   int   vecCount;
   int   missCount;
   int   ramReqCount;

   mem_load_align_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_load_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  func3;
      logic [31:0] rdata;
      logic        useRam;
      logic [31:0] expRamAddr;
      logic [31:0] expData;
      logic        expMis;
   } vec_t;

   vec_t vecs[16];

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count cycles in which a RAM request is presented
   initial ramReqCount = 0;
   always @(posedge clk) if (bus.ram_req) ramReqCount <= ramReqCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int i, input vec_t v);
      int startCnt;
      startCnt = ramReqCount;
      checkOutput($sformatf("v%0d ld_req_ready", i), 32'(bus.ld_req_ready), 32'd1);
      bus.ld_req_valid = 1'b1;
      bus.ld_addr      = v.addr;
      bus.ld_func3     = v.func3;
      tick();
      bus.ld_req_valid = 1'b0;
      bus.ld_addr      = '0;
      bus.ld_func3     = '0;
      if (v.useRam) begin
         checkOutput($sformatf("v%0d ram_req", i), 32'(bus.ram_req), 32'd1);
         checkOutput($sformatf("v%0d ram_addr", i), bus.ram_addr, v.expRamAddr);
         checkOutput($sformatf("v%0d early valid", i), 32'(bus.ld_rsp_valid), 32'd0);
         bus.ram_gnt = 1'b1;
         tick();
         bus.ram_gnt    = 1'b0;
         checkOutput($sformatf("v%0d ram_req drop", i), 32'(bus.ram_req), 32'd0);
         bus.ram_rvalid = 1'b1;
         bus.ram_rdata  = v.rdata;
         tick();
         bus.ram_rvalid = 1'b0;
         bus.ram_rdata  = '0;
      end
      checkOutput($sformatf("v%0d ld_rsp_valid", i), 32'(bus.ld_rsp_valid), 32'd1);
      checkOutput($sformatf("v%0d ld_rsp_data", i), bus.ld_rsp_data, v.expData);
      checkOutput($sformatf("v%0d missalign", i), 32'(bus.load_access_missalign), 32'(v.expMis));
      checkOutput($sformatf("v%0d busy ready", i), 32'(bus.ld_req_ready), 32'd0);
      checkOutput($sformatf("v%0d ram_req cycles", i), 32'(ramReqCount - startCnt), v.useRam ? 32'd1 : 32'd0);
      bus.ld_rsp_ready = 1'b1;
      tick();
      bus.ld_rsp_ready = 1'b0;
      checkOutput($sformatf("v%0d valid clear", i), 32'(bus.ld_rsp_valid), 32'd0);
      checkOutput($sformatf("v%0d data clear", i), bus.ld_rsp_data, 32'd0);
      checkOutput($sformatf("v%0d mis clear", i), 32'(bus.load_access_missalign), 32'd0);
   endtask

   initial begin
      int startCnt;
      vecCount  = 0;
      missCount = 0;
      rst_n            = 1'b0;
      bus.ld_req_valid = 1'b0;
      bus.ld_addr      = '0;
      bus.ld_func3     = '0;
      bus.ram_gnt      = 1'b0;
      bus.ram_rvalid   = 1'b0;
      bus.ram_rdata    = '0;
      bus.ld_rsp_ready = 1'b0;

      //            addr          f3      rdata         ram   ramAddr       expData       mis
      vecs[0]  = '{32'h0000_0103, 3'b000, 32'h8011_2233, 1'b1, 32'h0000_0100, 32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{32'h0000_0202, 3'b101, 32'hBEEF_1234, 1'b1, 32'h0000_0200, 32'h0000_BEEF, 1'b0};
      vecs[2]  = '{32'h0000_0202, 3'b001, 32'hBEEF_1234, 1'b1, 32'h0000_0200, 32'hFFFF_BEEF, 1'b0};
      vecs[3]  = '{32'h0000_0302, 3'b010, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1};
      vecs[4]  = '{32'h0000_0301, 3'b001, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1};
      vecs[5]  = '{32'h0000_0000, 3'b011, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
      vecs[6]  = '{32'h0000_0101, 3'b100, 32'h8011_2233, 1'b1, 32'h0000_0100, 32'h0000_0022, 1'b0};
      vecs[7]  = '{32'h0000_0102, 3'b000, 32'h80FF_2233, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0};
      vecs[8]  = '{32'h0000_0102, 3'b100, 32'h80FF_2233, 1'b1, 32'h0000_0100, 32'h0000_00FF, 1'b0};
      vecs[9]  = '{32'h0000_0500, 3'b001, 32'h1234_8765, 1'b1, 32'h0000_0500, 32'hFFFF_8765, 1'b0};
      vecs[10] = '{32'h0000_0500, 3'b101, 32'h1234_8765, 1'b1, 32'h0000_0500, 32'h0000_8765, 1'b0};
      vecs[11] = '{32'hABCD_0600, 3'b010, 32'hDEAD_BEEF, 1'b1, 32'hABCD_0600, 32'hDEAD_BEEF, 1'b0};
      vecs[12] = '{32'h0000_0203, 3'b101, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1};
      vecs[13] = '{32'h0000_0003, 3'b110, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
      vecs[14] = '{32'h0000_0002, 3'b111, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
      vecs[15] = '{32'h0000_0103, 3'b100, 32'h7F00_0000, 1'b1, 32'h0000_0100, 32'h0000_007F, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ld_req_ready", 32'(bus.ld_req_ready), 32'd1);
      checkOutput("reset ram_req", 32'(bus.ram_req), 32'd0);
      checkOutput("reset ram_addr", bus.ram_addr, 32'd0);
      checkOutput("reset ld_rsp_valid", 32'(bus.ld_rsp_valid), 32'd0);
      checkOutput("reset ld_rsp_data", bus.ld_rsp_data, 32'd0);
      checkOutput("reset missalign", 32'(bus.load_access_missalign), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table of single loads with immediate grant/rvalid
      for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);

      // LW with stalled grant, late rvalid, and a slow consumer
      startCnt = ramReqCount;
      bus.ld_req_valid = 1'b1;
      bus.ld_addr      = 32'h0000_0400;
      bus.ld_func3     = 3'b010;
      tick();
      bus.ld_req_valid = 1'b0;
      bus.ram_rvalid   = 1'b1;
      bus.ram_rdata    = 32'hBAD0_BAD0;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("stall req %0d", k), 32'(bus.ram_req), 32'd1);
         checkOutput($sformatf("stall addr %0d", k), bus.ram_addr, 32'h0000_0400);
         tick();
         bus.ram_rvalid = 1'b0;
         bus.ram_rdata  = '0;
      end
      checkOutput("stall addr at gnt", bus.ram_addr, 32'h0000_0400);
      checkOutput("stall no early rsp", 32'(bus.ld_rsp_valid), 32'd0);
      bus.ram_gnt = 1'b1;
      tick();
      bus.ram_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("wait no rsp %0d", k), 32'(bus.ld_rsp_valid), 32'd0);
         checkOutput($sformatf("wait no req %0d", k), 32'(bus.ram_req), 32'd0);
         tick();
      end
      bus.ram_rvalid = 1'b1;
      bus.ram_rdata  = 32'hCAFE_F00D;
      tick();
      bus.ram_rvalid = 1'b0;
      bus.ram_rdata  = '0;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("hold valid %0d", k), 32'(bus.ld_rsp_valid), 32'd1);
         checkOutput($sformatf("hold data %0d", k), bus.ld_rsp_data, 32'hCAFE_F00D);
         checkOutput($sformatf("hold mis %0d", k), 32'(bus.load_access_missalign), 32'd0);
         tick();
      end
      checkOutput("stall ram_req cycles", 32'(ramReqCount - startCnt), 32'd4);
      bus.ld_rsp_ready = 1'b1;
      bus.ld_req_valid = 1'b1;
      bus.ld_addr      = 32'h0000_0000;
      bus.ld_func3     = 3'b000;
      tick();
      bus.ld_rsp_ready = 1'b0;
      bus.ld_req_valid = 1'b0;
      checkOutput("handshake valid drop", 32'(bus.ld_rsp_valid), 32'd0);
      checkOutput("no accept on rsp cycle", 32'(bus.ld_req_ready), 32'd1);
      checkOutput("no req on rsp cycle", 32'(bus.ram_req), 32'd0);
      tick();
      checkOutput("single handshake", 32'(bus.ld_rsp_valid), 32'd0);

      // Reset while waiting for RAM data, then a stray rvalid
      bus.ld_req_valid = 1'b1;
      bus.ld_addr      = 32'h0000_0700;
      bus.ld_func3     = 3'b010;
      tick();
      bus.ld_req_valid = 1'b0;
      bus.ram_gnt      = 1'b1;
      tick();
      bus.ram_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rst ready", 32'(bus.ld_req_ready), 32'd1);
      checkOutput("async rst ram_addr", bus.ram_addr, 32'd0);
      checkOutput("async rst valid", 32'(bus.ld_rsp_valid), 32'd0);
      #2 rst_n = 1'b1;
      bus.ram_rvalid = 1'b1;
      bus.ram_rdata  = 32'h1111_1111;
      tick();
      bus.ram_rvalid = 1'b0;
      bus.ram_rdata  = '0;
      checkOutput("post rst no rsp", 32'(bus.ld_rsp_valid), 32'd0);
      checkOutput("post rst ready", 32'(bus.ld_req_ready), 32'd1);
      tick();
      checkOutput("post rst still no rsp", 32'(bus.ld_rsp_valid), 32'd0);
      checkOutput("post rst data", bus.ld_rsp_data, 32'd0);

      // Normal operation resumes after reset
      applyStimulus(100, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/mem_load_align.md
MEM_LOAD_ALIGN -- requirements
Module: mem_load_align

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, byte-address width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ld_req_valid  input  1  load request from pipeline.
REQ-005 ld_req_ready  output  1  block accepts a request this cycle.
REQ-006 ld_addr  input  ADDR_WIDTH  byte address of load.
REQ-007 ld_func3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 ram_req  output  1  RAM read request.
REQ-009 ram_addr  output  ADDR_WIDTH  word-aligned RAM address.
REQ-010 ram_gnt  input  1  RAM accepted ram_req this cycle.
REQ-011 ram_rvalid  input  1  ram_rdata valid this cycle.
REQ-012 ram_rdata  input  DATA_WIDTH  raw 32-bit word from RAM.
REQ-013 ld_rsp_valid  output  1  formatted result available.
REQ-014 ld_rsp_ready  input  1  consumer takes result.
REQ-015 ld_rsp_data  output  DATA_WIDTH  aligned, extended load result.
REQ-016 load_access_missalign  output  1  response is a misaligned-load fault; valid with ld_rsp_valid.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, RSP; ld_req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on ld_req_valid, SHALL register ld_addr, ld_func3 and classify: misaligned = (LH/LHU and addr[0]=1) or (LW and addr[1:0]!=00).
REQ-019 IDLE accept, misaligned: SHALL go to RSP with ld_rsp_data=0, load_access_missalign=1, no ram_req ever asserted.
REQ-020 IDLE accept, func3 in {011,110,111}: SHALL go to RSP with ld_rsp_data=0, load_access_missalign=0, no RAM access.
REQ-021 IDLE accept, legal aligned: SHALL go to REQ.
REQ-022 REQ: ram_req=1, ram_addr={addr[ADDR_WIDTH-1:2],2'b00} held stable until ram_gnt; on ram_gnt go to WAIT.
REQ-023 ram_rvalid SHALL be ignored in IDLE, REQ and RSP.
REQ-024 WAIT: on ram_rvalid, SHALL register formatted ram_rdata into ld_rsp_data, load_access_missalign=0, go to RSP.
REQ-025 Formatting, idx=addr[1:0]: LB = sign-extend ram_rdata[8*idx+7:8*idx]; LBU = zero-extend same byte.
REQ-026 LH = sign-extend ram_rdata[15:0] (idx 00) or [31:16] (idx 10); LHU = zero-extend same; LW = ram_rdata unchanged.
REQ-027 RSP: ld_rsp_valid=1, ld_rsp_data and load_access_missalign SHALL hold stable until ld_rsp_ready; on ld_rsp_ready go to IDLE, ld_rsp_valid=0 next cycle.
REQ-028 No new request SHALL be accepted in the cycle ld_rsp_ready is taken (one outstanding load max).
REQ-029 Minimum latency: accept cycle N, ram_gnt at N+1, ram_rvalid at N+2 -> ld_rsp_valid at N+3; fault path -> ld_rsp_valid at N+1.
REQ-030 ld_rsp_data and load_access_missalign SHALL be 0 whenever ld_rsp_valid=0.

Reset
REQ-031 On rst_n=0, asynchronously: state IDLE, ld_req_ready=1, ram_req=0, ram_addr=0, ld_rsp_valid=0, ld_rsp_data=0, load_access_missalign=0.
REQ-032 Reset mid-operation (REQ/WAIT/RSP) SHALL drop the pending load with no response; a later ram_rvalid SHALL be ignored.

Verification
REQ-033 LB addr 0x103, rdata 0x80112233, gnt/rvalid immediate -> ld_rsp_data 0xFFFFFF80 at N+3, missalign 0.
REQ-034 LHU addr 0x202, rdata 0xBEEF1234 -> 0x0000BEEF; LH same -> 0xFFFFBEEF; ram_addr 0x200.
REQ-035 LW addr 0x302 -> no ram_req, ld_rsp_valid at N+1, data 0, load_access_missalign 1; LH addr 0x301 same.
REQ-036 LW addr 0x400, ram_gnt delayed 3 cycles, rvalid 2 cycles later, ld_rsp_ready low 4 cycles -> ram_addr stable, data 0x... held, single handshake.
REQ-037 rst_n pulsed low in WAIT, then ram_rvalid=1 -> no ld_rsp_valid, ld_req_ready=1.
REQ-038 func3 011 addr 0x0 -> no ram_req, ld_rsp_data 0, missalign 0, ld_rsp_valid at N+1.
